// File: rtl/e203_exu_flush_sched.sv
// Pipeline-flush scheduler between commit and the IFU.
// Takes one flush from the branch-resolve path or the exception/IRQ path,
// holds it for the IFU valid/ready handshake, then waits out a refill drain
// window before it accepts the next flush. An exception may replace a branch
// flush that the IFU has not yet taken.
module e203_exu_flush_sched #(
   parameter int PC_SIZE   = 32,
   parameter int DRAIN_CYC = 2,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               brch_req,
   input  logic [PC_SIZE-1:0] brch_op1,
   input  logic [PC_SIZE-1:0] brch_op2,
   output logic               brch_ack,
   input  logic               excp_req,
   input  logic [PC_SIZE-1:0] excp_pc,
   output logic               excp_ack,
   output logic               ifu_flush_req,
   input  logic               ifu_flush_ack,
   output logic [PC_SIZE-1:0] ifu_flush_pc,
   output logic               ifu_flush_src,
   output logic               busy,
   output logic [CNT_W-1:0]   flush_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC);

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   state_e             state_q, state_d;
   logic [3:0]         drain_q, drain_d;
   logic [PC_SIZE-1:0] pc_q, pc_d;
   logic               src_q, src_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PC_SIZE-1:0] brch_tgt;

   // Branch target is the plain modular sum; the carry out is dropped.
   assign brch_tgt = brch_op1 + brch_op2;

   // State, drain counter, captured flush and handshake counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         drain_q <= 4'd0;
         pc_q    <= '0;
         src_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         pc_q    <= pc_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, capture and source-ack decode.
   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      pc_d     = pc_q;
      src_d    = src_q;
      cnt_d    = cnt_q;
      brch_ack = 1'b0;
      excp_ack = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Exception wins when both sources ask in the same cycle.
            if (excp_req) begin
               excp_ack = 1'b1;
               pc_d     = excp_pc;
               src_d    = 1'b1;
               state_d  = ST_PEND;
            end else if (brch_req) begin
               brch_ack = 1'b1;
               pc_d     = brch_tgt;
               src_d    = 1'b0;
               state_d  = ST_PEND;
            end
         end
         ST_PEND: begin
            if (ifu_flush_ack) begin
               cnt_d = sat_inc(cnt_q);
               if (DRAIN_CYC == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  drain_d = DRAIN_INIT;
                  state_d = ST_DRAIN;
               end
            end else if (!src_q && excp_req) begin
               // A waiting branch flush is replaced by the exception and dropped.
               excp_ack = 1'b1;
               pc_d     = excp_pc;
               src_d    = 1'b1;
            end
         end
         ST_DRAIN: begin
            drain_d = (drain_q != 4'd0) ? drain_q - 4'd1 : 4'd0;
            if (drain_q <= 4'd1) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ifu_flush_req = (state_q == ST_PEND);
   assign ifu_flush_pc  = pc_q;
   assign ifu_flush_src = src_q;
   assign busy          = (state_q != ST_IDLE);
   assign flush_cnt     = cnt_q;

endmodule
